// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, NOP encoding and the {pc, insn} record for the fetch stage
package fetch_pkg;
  localparam int PC_W = 32;
  localparam int INSN_W = 32;
  localparam logic [INSN_W-1:0] NOP_INSN = '0;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fd_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: 2-entry FIFO of {pc, insn} absorbing the in-flight imem read during a stall
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  fd_entry_t  push_data,
  input  logic       pop,
  output logic [1:0] cnt,
  output fd_entry_t  head
);
  fd_entry_t mem [2];
  logic hd, tl;
  assign head = mem[hd];
  always_ff @(posedge clk)
    if (push) mem[tl] <= push_data;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt <= '0;
      hd  <= 1'b0;
      tl  <= 1'b0;
    end else begin
      if (push) tl <= ~tl;
      if (pop) hd <= ~hd;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
  always_ff @(posedge clk)
    if (!reset && !flush)
      assert (!(push && !pop && cnt == 2'd2)) else $error("skid buffer overflow");
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem issue with one-cycle read latency, skid-buffered valid/ready toward decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          IMEM_AW  = 12,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] address_imem,
  input  logic [31:0]        q_imem,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               fd_valid,
  input  logic               fd_ready,
  output logic [31:0]        fd_pc,
  output logic [31:0]        fd_insn
);
  logic [PC_W-1:0] pc_q, rsp_pc_q;
  logic rsp_valid_q, fire, pop, push, issue;
  logic [1:0] cnt;
  logic [2:0] occ;
  fd_entry_t head, sel;
  assign address_imem = pc_q[IMEM_AW-1:0];
  always_comb begin
    sel      = (cnt != 2'd0) ? head : fd_entry_t'({rsp_pc_q, q_imem});
    fd_valid = ~redirect_valid & ((cnt != 2'd0) | rsp_valid_q);
    fire     = fd_valid & fd_ready;
    pop      = fire & (cnt != 2'd0);
    push     = rsp_valid_q & ~redirect_valid & ~(fire & (cnt == 2'd0));
    occ      = 3'(cnt) + 3'(rsp_valid_q) - 3'(fire);
    issue    = (occ < 3'd2) & ~redirect_valid;
    fd_pc    = sel.pc;
    fd_insn  = fd_valid ? sel.insn : NOP_INSN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      rsp_valid_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= redirect_pc;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= issue;
      if (issue) begin
        rsp_pc_q <= pc_q;
        pc_q     <= pc_q + PC_STEP;
      end
    end
  end
  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (fd_entry_t'({rsp_pc_q, q_imem})),
    .pop       (pop),
    .cnt       (cnt),
    .head      (head)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a stream-level reference model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_imem;
  logic [31:0] q_imem = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fd_valid;
  logic        fd_ready = 1'b0;
  logic [31:0] fd_pc, fd_insn;
  int n_cmp = 0, n_bad = 0, fires = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_pc(fd_pc), .fd_insn(fd_insn)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(logic [31:0] pc);
    return 32'(pc[11:0]) + 32'd100;
  endfunction

  always @(posedge clk) q_imem <= ins_of(32'(address_imem));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
    end
  endtask

  // Decode-side view: one unbroken PC sequence from each reset/redirect target,
  // first item two cycles after the event, valid never drops once streaming, stalls hold.
  bit armed = 0, must = 0, hold = 0, after_rst = 0;
  int cd = 0;
  logic [31:0] exp_pc, hpc, hins;
  always @(negedge clk) begin
    if (reset) begin
      armed = 1; exp_pc = 32'd0; cd = 1; must = 0; hold = 0; after_rst = 1;
    end else if (armed) begin
      if (after_rst) chk("rst_addr", 32'(address_imem), 32'd0);
      after_rst = 0;
      if (redirect_valid) begin
        chk("redir_valid", 32'(fd_valid), 32'd0);
        exp_pc = redirect_pc; cd = 1; must = 0; hold = 0;
      end else begin
        if (cd > 0) begin
          chk("fill_valid", 32'(fd_valid), 32'd0);
          cd--;
          must = (cd == 0);
        end else if (must) chk("stream_valid", 32'(fd_valid), 32'd1);
        if (hold) begin
          chk("hold_pc", fd_pc, hpc);
          chk("hold_insn", fd_insn, hins);
        end
        if (fd_valid && fd_ready) begin
          chk("seq_pc", fd_pc, exp_pc);
          chk("seq_insn", fd_insn, ins_of(exp_pc));
          exp_pc = exp_pc + 32'd1;
          fires++;
        end
        hold = fd_valid && !fd_ready;
        hpc = fd_pc;
        hins = fd_insn;
      end
    end
  end

  typedef struct {
    logic rst, rdy, rv;
    logic [31:0] rpc;
    int ev;
    logic [31:0] epc;
    int ecnt, eaddr;
  } vec_t;
  vec_t vq[$];

  function automatic void add(logic rst, logic rdy, logic rv, logic [31:0] rpc,
                              int ev, logic [31:0] epc, int ecnt, int eaddr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    vq.push_back(v);
  endfunction

  initial begin
    add(1, 1, 0, 0, -1, 0, -1, -1);
    add(0, 1, 0, 0, 0, 0, -1, 0);
    for (int p = 0; p < 5; p++) add(0, 1, 0, 0, 1, 32'(p), -1, -1);
    add(0, 0, 0, 0, 1, 5, -1, -1);
    add(0, 0, 0, 0, 1, 5, 1, -1);
    add(0, 0, 0, 0, 1, 5, 2, 7);
    add(0, 0, 0, 0, 1, 5, 2, 7);
    for (int p = 5; p < 8; p++) add(0, 1, 0, 0, 1, 32'(p), -1, -1);
    add(0, 1, 1, 32'h40, 0, 0, -1, -1);
    add(0, 1, 0, 0, 0, 0, -1, -1);
    add(0, 1, 0, 0, 1, 32'h40, -1, -1);
    add(0, 1, 0, 0, 1, 32'h41, -1, -1);
    add(0, 0, 0, 0, 1, 32'h42, 0, -1);
    add(0, 0, 0, 0, 1, 32'h42, 1, -1);
    add(0, 0, 0, 0, 1, 32'h42, 2, 32'h44);
    add(0, 0, 1, 32'h200, 0, 0, -1, -1);
    add(0, 1, 0, 0, 0, 0, 0, -1);
    add(0, 1, 0, 0, 1, 32'h200, -1, -1);
    add(0, 1, 0, 0, 1, 32'h201, -1, -1);
    add(0, 1, 1, 32'hFFFFFFFF, 0, 0, -1, -1);
    add(0, 1, 0, 0, 0, 0, -1, -1);
    add(0, 1, 0, 0, 1, 32'hFFFFFFFF, -1, -1);
    add(0, 1, 0, 0, 1, 32'h0, -1, -1);
    add(0, 1, 0, 0, 1, 32'h1, -1, -1);
    add(0, 0, 0, 0, 1, 2, 0, -1);
    add(0, 0, 0, 0, 1, 2, 1, -1);
    add(0, 0, 0, 0, 1, 2, 2, 4);
    add(1, 0, 0, 0, -1, 0, -1, -1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, -1, -1);
    add(0, 1, 0, 0, 1, 1, -1, -1);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      reset = vq[i].rst; fd_ready = vq[i].rdy;
      redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
      @(negedge clk);
      if (vq[i].ev >= 0) chk($sformatf("vec%0d_valid", i), 32'(fd_valid), 32'(vq[i].ev));
      if (vq[i].ev == 1) begin
        chk($sformatf("vec%0d_pc", i), fd_pc, vq[i].epc);
        chk($sformatf("vec%0d_insn", i), fd_insn, ins_of(vq[i].epc));
      end
      if (vq[i].ecnt >= 0) chk($sformatf("vec%0d_cnt", i), 32'(dut.u_skid.cnt), 32'(vq[i].ecnt));
      if (vq[i].eaddr >= 0) chk($sformatf("vec%0d_addr", i), 32'(address_imem), 32'(vq[i].eaddr));
    end

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 199) == 0);
      fd_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFD + 32'($urandom_range(0, 2)) : $urandom;
    end
    @(posedge clk); #1;
    reset = 1'b0; redirect_valid = 1'b0; fd_ready = 1'b1;
    @(negedge clk);
    chk("enough_fires", 32'(fires > 1000), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
